plic_claim_ctrl: RTL and testbench

- Per-core claim/complete responder sitting between the PLIC routing stage and the per-core CSR/MMIO claim registers.
- Samples each core's routed interrupt (external_int, source ID) when the core issues a claim, and returns the ID.
- Holds a per-IRQ in-service mask until the core writes complete, and gates IRQ enables with that mask so the claimed source is not re-presented.

---
 rtl/plic_claim_ctrl.sv | 133 +++++++++++++
 tb/tb_plic_claim_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// Per-core PLIC claim/complete responder: latches the claimed source ID per core and
// masks it from the routing stage until the matching completion arrives.
module plic_claim_ctrl #(
  parameter int unsigned NIRQ  = 18,
  parameter int unsigned NCORE = 4,
  parameter int unsigned SRC_W = $clog2(NIRQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NCORE-1:0]            external_int,
  input  logic [NCORE-1:0][SRC_W-1:0] intr_src,
  input  logic [NIRQ-1:0]             s2b_intr_en,
  output logic [NIRQ-1:0]             intr_en_gated,
  output logic [NIRQ-1:0]             irq_in_service,
  input  logic [NCORE-1:0]            claim_valid,
  output logic [NCORE-1:0]            claim_rvalid,
  output logic [NCORE-1:0][SRC_W-1:0] claim_rid,
  output logic [NCORE-1:0]            claim_rnone,
  input  logic [NCORE-1:0]            complete_valid,
  input  logic [NCORE-1:0][SRC_W-1:0] complete_id,
  output logic [NCORE-1:0]            cmpl_err,
  input  logic [NCORE-1:0]            cmpl_err_clr
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CLAIMED = 1'b1
  } state_e;

  localparam logic [SRC_W:0] LP_NIRQ = (SRC_W+1)'(NIRQ);

  state_e                      r_state     [NCORE];
  state_e                      w_state_nxt [NCORE];
  logic [NCORE-1:0][SRC_W-1:0] r_held_id;
  logic [NCORE-1:0][SRC_W-1:0] w_held_nxt;
  logic [NCORE-1:0]            r_rvalid;
  logic [NCORE-1:0]            w_rvalid_nxt;
  logic [NCORE-1:0][SRC_W-1:0] r_rid;
  logic [NCORE-1:0][SRC_W-1:0] w_rid_nxt;
  logic [NCORE-1:0]            r_rnone;
  logic [NCORE-1:0]            w_rnone_nxt;
  logic [NCORE-1:0]            r_err;
  logic [NCORE-1:0]            w_err_nxt;
  logic [NIRQ-1:0]             r_in_service;
  logic [NIRQ-1:0]             w_in_service_nxt;
  logic [NCORE-1:0]            w_cmpl_ok;
  logic [NCORE-1:0]            w_cmpl_bad;
  logic [NCORE-1:0]            w_src_ok;

  // Completion resolves first so a same-cycle claim sees the post-complete state.
  always_comb begin
    w_state_nxt  = r_state;
    w_held_nxt   = r_held_id;
    w_rvalid_nxt = '0;
    w_rid_nxt    = r_rid;
    w_rnone_nxt  = '0;
    w_err_nxt    = r_err;
    w_cmpl_ok    = '0;
    w_cmpl_bad   = '0;
    w_src_ok     = '0;
    for (int unsigned c = 0; c < NCORE; c++) begin
      w_cmpl_ok[c]  = complete_valid[c] && (r_state[c] == ST_CLAIMED) &&
                      (complete_id[c] == r_held_id[c]);
      w_cmpl_bad[c] = complete_valid[c] && !w_cmpl_ok[c];
      w_src_ok[c]   = external_int[c] && ({1'b0, intr_src[c]} < LP_NIRQ);

      if (w_cmpl_ok[c]) begin
        w_state_nxt[c] = ST_IDLE;
        w_held_nxt[c]  = '0;
      end

      if (claim_valid[c]) begin
        w_rvalid_nxt[c] = 1'b1;
        if (w_state_nxt[c] == ST_CLAIMED) begin
          w_rid_nxt[c] = r_held_id[c];
        end else if (w_src_ok[c]) begin
          w_rid_nxt[c]   = intr_src[c];
          w_state_nxt[c] = ST_CLAIMED;
          w_held_nxt[c]  = intr_src[c];
        end else begin
          w_rid_nxt[c]   = '0;
          w_rnone_nxt[c] = 1'b1;
        end
      end

      w_err_nxt[c] = w_cmpl_bad[c] | (r_err[c] & ~cmpl_err_clr[c]);
    end
  end

  // Mask is built from next state so claim/complete take effect on the mask one cycle later.
  always_comb begin
    w_in_service_nxt = '0;
    for (int unsigned j = 0; j < NIRQ; j++) begin
      for (int unsigned c = 0; c < NCORE; c++) begin
        if ((w_state_nxt[c] == ST_CLAIMED) && (w_held_nxt[c] == SRC_W'(j))) begin
          w_in_service_nxt[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCORE; c++) begin
        r_state[c] <= ST_IDLE;
      end
      r_held_id    <= '0;
      r_rvalid     <= '0;
      r_rid        <= '0;
      r_rnone      <= '0;
      r_err        <= '0;
      r_in_service <= '0;
    end else begin
      for (int unsigned c = 0; c < NCORE; c++) begin
        r_state[c] <= w_state_nxt[c];
      end
      r_held_id    <= w_held_nxt;
      r_rvalid     <= w_rvalid_nxt;
      r_rid        <= w_rid_nxt;
      r_rnone      <= w_rnone_nxt;
      r_err        <= w_err_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  assign irq_in_service = r_in_service;
  assign intr_en_gated  = s2b_intr_en & ~r_in_service;
  assign claim_rvalid   = r_rvalid;
  assign claim_rid      = r_rid;
  assign claim_rnone    = r_rnone;
  assign cmpl_err       = r_err;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed table-driven bench for plic_claim_ctrl with hand-computed expectations.
module tb_plic_claim_ctrl;
  localparam int unsigned NIRQ  = 18;
  localparam int unsigned NCORE = 4;
  localparam int unsigned SRC_W = 5;
  localparam logic [17:0] ALL   = 18'h3FFFF;

  logic                        clk;
  logic                        rst_n;
  logic [NCORE-1:0]            external_int;
  logic [NCORE-1:0][SRC_W-1:0] intr_src;
  logic [NIRQ-1:0]             s2b_intr_en;
  logic [NIRQ-1:0]             intr_en_gated;
  logic [NIRQ-1:0]             irq_in_service;
  logic [NCORE-1:0]            claim_valid;
  logic [NCORE-1:0]            claim_rvalid;
  logic [NCORE-1:0][SRC_W-1:0] claim_rid;
  logic [NCORE-1:0]            claim_rnone;
  logic [NCORE-1:0]            complete_valid;
  logic [NCORE-1:0][SRC_W-1:0] complete_id;
  logic [NCORE-1:0]            cmpl_err;
  logic [NCORE-1:0]            cmpl_err_clr;

  plic_claim_ctrl #(
    .NIRQ (NIRQ),
    .NCORE(NCORE),
    .SRC_W(SRC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .external_int  (external_int),
    .intr_src      (intr_src),
    .s2b_intr_en   (s2b_intr_en),
    .intr_en_gated (intr_en_gated),
    .irq_in_service(irq_in_service),
    .claim_valid   (claim_valid),
    .claim_rvalid  (claim_rvalid),
    .claim_rid     (claim_rid),
    .claim_rnone   (claim_rnone),
    .complete_valid(complete_valid),
    .complete_id   (complete_id),
    .cmpl_err      (cmpl_err),
    .cmpl_err_clr  (cmpl_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ext;
    logic [19:0] src;
    logic [3:0]  clv;
    logic [3:0]  cpv;
    logic [19:0] cpid;
    logic [3:0]  clr;
    logic [17:0] en;
    logic [3:0]  e_rv;
    logic [19:0] e_rid;
    logic [3:0]  e_rn;
    logic [3:0]  e_err;
    logic [17:0] e_ins;
  } vec_t;

  int   n_pass;
  int   n_total;
  vec_t vecs[$];

  function automatic logic [19:0] pk(int a3, int a2, int a1, int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic vec_t mk(string nm, logic [3:0] ext, logic [19:0] src, logic [3:0] clv,
                              logic [3:0] cpv, logic [19:0] cpid, logic [3:0] clr,
                              logic [17:0] en, logic [3:0] erv, logic [19:0] erid,
                              logic [3:0] ern, logic [3:0] eerr, logic [17:0] eins);
    vec_t v;
    v.name = nm;  v.ext = ext;   v.src = src;   v.clv = clv;  v.cpv = cpv;
    v.cpid = cpid; v.clr = clr;  v.en = en;     v.e_rv = erv; v.e_rid = erid;
    v.e_rn = ern; v.e_err = eerr; v.e_ins = eins;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(string nm, logic [3:0] erv, logic [19:0] erid, logic [3:0] ern,
                         logic [3:0] eerr, logic [17:0] eins, logic [17:0] en);
    chk({nm, ".rvalid"}, 32'(claim_rvalid), 32'(erv));
    chk({nm, ".rid"},    32'(claim_rid),    32'(erid));
    chk({nm, ".rnone"},  32'(claim_rnone),  32'(ern));
    chk({nm, ".err"},    32'(cmpl_err),     32'(eerr));
    chk({nm, ".ins"},    32'(irq_in_service), 32'(eins));
    chk({nm, ".gated"},  32'(intr_en_gated),  32'(en & ~eins));
  endtask

  task automatic drive_idle();
    external_int   = '0;
    intr_src       = '0;
    claim_valid    = '0;
    complete_valid = '0;
    complete_id    = '0;
    cmpl_err_clr   = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    s2b_intr_en = 18'h2F0F3;
    drive_idle();

    vecs.push_back(mk("claim_c1_irq5",      4'b0010, pk(0,0,5,0),  4'b0010, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b0010, pk(0,0,5,0),   4'b0000, 4'b0000, 18'h00020));
    vecs.push_back(mk("idle_hold",          4'b0000, pk(0,0,0,0),  4'b0000, 4'b0000, pk(0,0,0,0),  4'b0000, 18'h2AAAA, 4'b0000, pk(0,0,5,0),   4'b0000, 4'b0000, 18'h00020));
    vecs.push_back(mk("cmpl_c1_5",          4'b0000, pk(0,0,0,0),  4'b0000, 4'b0010, pk(0,0,5,0),  4'b0000, 18'h155FF, 4'b0000, pk(0,0,5,0),   4'b0000, 4'b0000, 18'h00000));
    vecs.push_back(mk("rnone_c2",           4'b0000, pk(0,9,0,0),  4'b0100, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b0100, pk(0,0,5,0),   4'b0100, 4'b0000, 18'h00000));
    vecs.push_back(mk("claim_c0_irq3",      4'b0001, pk(0,0,0,3),  4'b0001, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b0001, pk(0,0,5,3),   4'b0000, 4'b0000, 18'h00008));
    vecs.push_back(mk("bad_cmpl_c0",        4'b0000, pk(0,0,0,0),  4'b0000, 4'b0001, pk(0,0,0,4),  4'b0000, ALL,       4'b0000, pk(0,0,5,3),   4'b0000, 4'b0001, 18'h00008));
    vecs.push_back(mk("repeat_claim_c0",    4'b0000, pk(0,0,0,0),  4'b0001, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b0001, pk(0,0,5,3),   4'b0000, 4'b0001, 18'h00008));
    vecs.push_back(mk("err_set_wins",       4'b0000, pk(0,0,0,0),  4'b0000, 4'b0001, pk(0,0,0,9),  4'b0001, ALL,       4'b0000, pk(0,0,5,3),   4'b0000, 4'b0001, 18'h00008));
    vecs.push_back(mk("err_clr_c0",         4'b0000, pk(0,0,0,0),  4'b0000, 4'b0000, pk(0,0,0,0),  4'b0001, ALL,       4'b0000, pk(0,0,5,3),   4'b0000, 4'b0000, 18'h00008));
    vecs.push_back(mk("claim_cmpl_same_c0", 4'b0001, pk(0,0,0,7),  4'b0001, 4'b0001, pk(0,0,0,3),  4'b0000, ALL,       4'b0001, pk(0,0,5,7),   4'b0000, 4'b0000, 18'h00080));
    vecs.push_back(mk("src_oob_c3",         4'b1000, pk(18,0,0,0), 4'b1000, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b1000, pk(0,0,5,7),   4'b1000, 4'b0000, 18'h00080));
    vecs.push_back(mk("cmpl_idle_c2",       4'b0000, pk(0,0,0,0),  4'b0000, 4'b0100, pk(0,0,0,0),  4'b0000, ALL,       4'b0000, pk(0,0,5,7),   4'b0000, 4'b0100, 18'h00080));
    vecs.push_back(mk("bad_cmpl_claim_c2",  4'b0100, pk(0,12,0,0), 4'b0100, 4'b0100, pk(0,1,0,0),  4'b0000, ALL,       4'b0100, pk(0,12,5,7),  4'b0000, 4'b0100, 18'h01080));
    vecs.push_back(mk("claim_c1_17_c3_0",   4'b1010, pk(0,0,17,0), 4'b1010, 4'b0000, pk(0,0,0,0),  4'b0000, 18'h3F0F0, 4'b1010, pk(0,12,17,7), 4'b0000, 4'b0100, 18'h21081));
    vecs.push_back(mk("bad_cmpl_repeat_c1", 4'b0010, pk(0,0,3,0),  4'b0010, 4'b0010, pk(0,0,16,0), 4'b0000, ALL,       4'b0010, pk(0,12,17,7), 4'b0000, 4'b0110, 18'h21081));
    vecs.push_back(mk("cmpl_c2_c3",         4'b0000, pk(0,0,0,0),  4'b0000, 4'b1100, pk(0,12,0,0), 4'b0000, ALL,       4'b0000, pk(0,12,17,7), 4'b0000, 4'b0110, 18'h20080));
    vecs.push_back(mk("claim_c2_4_c3_5",    4'b1100, pk(5,4,0,0),  4'b1100, 4'b0000, pk(0,0,0,0),  4'b0000, ALL,       4'b1100, pk(5,4,17,7),  4'b0000, 4'b0110, 18'h200B0));

    // Reset state while held in reset
    #12;
    chk_all("reset", 4'b0000, 20'h0, 4'b0000, 4'b0000, 18'h0, s2b_intr_en);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      external_int   = vecs[i].ext;
      intr_src       = vecs[i].src;
      claim_valid    = vecs[i].clv;
      complete_valid = vecs[i].cpv;
      complete_id    = vecs[i].cpid;
      cmpl_err_clr   = vecs[i].clr;
      s2b_intr_en    = vecs[i].en;
      @(posedge clk);
      #1;
      chk_all(vecs[i].name, vecs[i].e_rv, vecs[i].e_rid, vecs[i].e_rn, vecs[i].e_err,
              vecs[i].e_ins, vecs[i].en);
    end

    // Async reset between edges with all cores claimed and a claim/complete in flight
    @(negedge clk);
    external_int   = 4'b1111;
    intr_src       = pk(9, 10, 11, 13);
    claim_valid    = 4'b1111;
    complete_valid = 4'b0001;
    complete_id    = pk(0, 0, 0, 7);
    s2b_intr_en    = 18'h1234F;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 20'h0, 4'b0000, 4'b0000, 18'h0, 18'h1234F);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_quiet", 4'b0000, 20'h0, 4'b0000, 4'b0000, 18'h0, 18'h1234F);

    @(negedge clk);
    external_int = 4'b0001;
    intr_src     = pk(0, 0, 0, 2);
    claim_valid  = 4'b0001;
    @(posedge clk);
    #1;
    chk_all("post_reset_claim", 4'b0001, pk(0,0,0,2), 4'b0000, 4'b0000, 18'h00004, 18'h1234F);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk_all("pulse_drop", 4'b0000, pk(0,0,0,2), 4'b0000, 4'b0000, 18'h00004, 18'h1234F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
